// File: rtl/rpn_token_serializer.sv
// Serializes number/operator tokens into the RPN calculator's single-bit frame
// protocol, inserts inter-frame idle gaps and tracks a shadow stack-depth model.
module rpn_token_serializer #(
    parameter  int STACK_DEPTH = 16,
    parameter  int NUM_GAP     = 0,
    parameter  int OP_GAP      = 2,
    parameter  int STREAM_GAP  = 12,
    localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_is_op,
    input  logic [7:0]    in_data,
    input  logic [1:0]    in_op,
    output logic          dOut,
    output logic          busy,
    output logic [DW-1:0] depth,
    output logic          pred_overflow,
    output logic          pred_underflow
);

    localparam int MAXG  = (NUM_GAP > OP_GAP) ? ((NUM_GAP > STREAM_GAP) ? NUM_GAP : STREAM_GAP)
                                              : ((OP_GAP > STREAM_GAP) ? OP_GAP : STREAM_GAP);
    localparam int MAXC  = (MAXG > 10) ? MAXG : 10;
    localparam int CW    = $clog2(MAXC + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t        r_state;
    logic [9:0]    r_shift;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_gap;
    logic          r_dout;
    logic          r_ready;
    logic          r_busy;
    logic [DW-1:0] r_depth;
    logic          r_ovf;
    logic          r_unf;

    logic          w_accept;
    logic [9:0]    w_frame;
    logic [CW-1:0] w_len;
    logic [CW-1:0] w_gap_sel;

    // r_ready mirrors (r_state == S_IDLE), so acceptance needs no state decode
    assign w_accept = in_valid && r_ready;

    always_comb begin
        w_frame   = {2'b10, in_data};
        w_len     = CW'(10);
        w_gap_sel = CW'(NUM_GAP);
        if (in_is_op) begin
            w_frame   = {2'b11, in_op, 6'b0};
            w_len     = CW'(4);
            w_gap_sel = (in_op == 2'b11) ? CW'(STREAM_GAP) : CW'(OP_GAP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_dout  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dout <= 1'b0;
                    if (w_accept) begin
                        r_shift <= w_frame;
                        r_cnt   <= w_len;
                        r_gap   <= w_gap_sel;
                        r_state <= S_SEND;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SEND: begin
                    r_dout  <= r_shift[9];
                    r_shift <= {r_shift[8:0], 1'b0};
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        if (r_gap == '0) begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_GAP;
                            r_cnt   <= r_gap;
                        end
                    end
                end
                S_GAP: begin
                    r_dout <= 1'b0;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_dout  <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Shadow stack model: predicts calculator flags, never blocks tokens
    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (w_accept) begin
            if (!in_is_op) begin
                if (r_depth == DW'(STACK_DEPTH)) r_ovf   <= 1'b1;
                else                             r_depth <= r_depth + DW'(1);
            end else begin
                case (in_op)
                    2'b00: r_depth <= '0;
                    2'b01, 2'b10: begin
                        if (r_depth < DW'(2)) begin
                            r_unf   <= 1'b1;
                            r_depth <= DW'(1);
                        end else begin
                            r_depth <= r_depth - DW'(1);
                        end
                    end
                    default: r_depth <= r_depth;
                endcase
            end
        end
    end

    assign in_ready       = r_ready;
    assign dOut           = r_dout;
    assign busy           = r_busy;
    assign depth          = r_depth;
    assign pred_overflow  = r_ovf;
    assign pred_underflow = r_unf;

endmodule
